// File: rtl/player_pkg.sv
// Shared types and constants for the player sprite controller.
package player_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERASE = 3'd1,
    MOVE  = 3'd2,
    DRAW  = 3'd3,
    DEAD  = 3'd4
  } player_state_t;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  localparam int OFF_W = 4;

  // One horizontal step; both or neither direction means no move.
  function automatic logic [7:0] step_x(input logic [7:0] x,
                                        input logic [7:0] step,
                                        input logic [7:0] x_max,
                                        input logic       go_left,
                                        input logic       go_right);
    logic [8:0] sum;
    sum    = {1'b0, x} + {1'b0, step};
    step_x = x;
    if (go_left && !go_right)
      step_x = (x >= step) ? x - step : 8'd0;
    else if (go_right && !go_left)
      step_x = (sum > {1'b0, x_max}) ? x_max : sum[7:0];
  endfunction

endpackage

// File: rtl/sprite_scanner.sv
// Row-major pixel offset generator (column fastest) for one sprite pass.
module sprite_scanner
  import player_pkg::*;
#(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             advance,
  output logic [OFF_W-1:0] col,
  output logic [OFF_W-1:0] row,
  output logic             last
);

  localparam logic [OFF_W-1:0] COL_MAX = OFF_W'(SPR_W - 1);
  localparam logic [OFF_W-1:0] ROW_MAX = OFF_W'(SPR_H - 1);

  assign last = (col == COL_MAX) && (row == ROW_MAX);

  always_ff @(posedge clk) begin
    if (reset_n || start) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Player sprite controller: erase / move / redraw per frame tick, lives tracking.
// Optional build macro PLAYER_HIT_FLASH_EN draws the frame after a hit in red.
//
// state | meaning
// IDLE  | waiting for tick
// ERASE | N black pixels at old position
// MOVE  | apply hit / left / right, one cycle
// DRAW  | N sprite pixels at new position
// DEAD  | lives exhausted, held until reset
module player_ctrl
  import player_pkg::*;
#(
  parameter int         SPR_W    = 4,
  parameter int         SPR_H    = 4,
  parameter int         SCREEN_W = 160,
  parameter int         START_X  = 78,
  parameter int         START_Y  = 100,
  parameter int         STEP     = 1,
  parameter int         LIVES    = 3,
  parameter logic [2:0] COLOUR   = 3'b111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       left,
  input  logic       right,
  input  logic       got_hit,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done,
  output logic [1:0] lives,
  output logic       dead
);

  localparam logic [7:0] X_MAX      = 8'(SCREEN_W - SPR_W);
  localparam logic [7:0] X_SPAWN    = 8'(START_X);
  localparam logic [6:0] Y_SPAWN    = 7'(START_Y);
  localparam logic [7:0] STEP_X     = 8'(STEP);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  player_state_t    state, next_state;
  logic [OFF_W-1:0] col, row;
  logic             scan_last, scan_start, scan_adv;
  logic             hit_pending, hit_now;
  logic             left_q, right_q;
  logic [2:0]       draw_colour;

  sprite_scanner #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scanner (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (scan_start),
    .advance (scan_adv),
    .col     (col),
    .row     (row),
    .last    (scan_last)
  );

  // A hit arriving in the MOVE cycle itself still counts for this frame.
  assign hit_now = hit_pending | got_hit;
  assign dead    = (state == DEAD);

`ifdef PLAYER_HIT_FLASH_EN
  logic flash_q;

  always_ff @(posedge clk) begin
    if (reset_n)
      flash_q <= 1'b0;
    else if (state == MOVE)
      flash_q <= hit_now;
  end

  assign draw_colour = flash_q ? RED : COLOUR;
`else
  assign draw_colour = COLOUR;
`endif

  always_ff @(posedge clk) begin
    if (reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    plot       = 1'b0;
    colour     = BLACK;
    plot_x     = 8'd0;
    plot_y     = 7'd0;
    case (state)
      IDLE: begin
        if (tick) begin
          next_state = ERASE;
          scan_start = 1'b1;
        end
      end
      ERASE: begin
        plot     = 1'b1;
        colour   = BLACK;
        plot_x   = x_pos + {4'b0000, col};
        plot_y   = y_pos + {3'b000, row};
        scan_adv = 1'b1;
        if (scan_last)
          next_state = MOVE;
      end
      MOVE: begin
        scan_start = 1'b1;
        next_state = (hit_now && lives == 2'd1) ? DEAD : DRAW;
      end
      DRAW: begin
        plot     = 1'b1;
        colour   = draw_colour;
        plot_x   = x_pos + {4'b0000, col};
        plot_y   = y_pos + {3'b000, row};
        scan_adv = 1'b1;
        if (scan_last)
          next_state = IDLE;
      end
      DEAD: next_state = DEAD;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      x_pos       <= X_SPAWN;
      y_pos       <= Y_SPAWN;
      lives       <= LIVES_INIT;
      hit_pending <= 1'b0;
      done        <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
    end else begin
      done <= (state == DRAW) && scan_last;
      if (state == IDLE && tick) begin
        left_q  <= left;
        right_q <= right;
      end
      if (state == MOVE) begin
        hit_pending <= 1'b0;
        if (hit_now) begin
          lives <= lives - 2'd1;
          x_pos <= X_SPAWN;
          y_pos <= Y_SPAWN;
        end else begin
          x_pos <= step_x(x_pos, STEP_X, X_MAX, left_q, right_q);
        end
      end else begin
        hit_pending <= hit_now;
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: vector table, directed corner sequences, random frames vs model.
module tb_player_ctrl;

  localparam int W        = 4;
  localparam int H        = 4;
  localparam int N        = W * H;
  localparam int SCREEN_W = 160;
  localparam int START_X  = 78;
  localparam int START_Y  = 100;
  localparam int STEP     = 1;
  localparam int X_MAX    = SCREEN_W - W;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, left = 1'b0, right = 1'b0, got_hit = 1'b0;
  logic [7:0] x_pos, plot_x;
  logic [6:0] y_pos, plot_y;
  logic [2:0] colour;
  logic       plot, done, dead;
  logic [1:0] lives;

  int errors = 0;
  int checks = 0;

  int m_x, m_y, m_lives;
  bit m_hit, m_dead;

  typedef struct {
    bit l;
    bit r;
    bit hit;
    int exp_x;
    int exp_lives;
  } vec_t;

  vec_t vecs [6];

  player_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .left    (left),
    .right   (right),
    .got_hit (got_hit),
    .x_pos   (x_pos),
    .y_pos   (y_pos),
    .plot_x  (plot_x),
    .plot_y  (plot_y),
    .colour  (colour),
    .plot    (plot),
    .done    (done),
    .lives   (lives),
    .dead    (dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_move(input int x, input bit l, input bit r);
    if (l && !r) return (x - STEP < 0) ? 0 : x - STEP;
    if (r && !l) return (x + STEP > X_MAX) ? X_MAX : x + STEP;
    return x;
  endfunction

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_lives = 3; m_hit = 0; m_dead = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1; tick = 1'b0; left = 1'b0; right = 1'b0; got_hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_dead"}, int'(dead), 0);
    chk({tag, "_x"}, int'(x_pos), START_X);
    chk({tag, "_y"}, int'(y_pos), START_Y);
    chk({tag, "_lives"}, int'(lives), 3);
    chk({tag, "_plot_x"}, int'(plot_x), 0);
    chk({tag, "_plot_y"}, int'(plot_y), 0);
    chk({tag, "_colour"}, int'(colour), 0);
  endtask

  task automatic pulse_hit();
    @(negedge clk);
    got_hit = 1'b1;
    @(negedge clk);
    got_hit = 1'b0;
    m_hit = 1;
  endtask

  // Called at a negedge while idle; drives one frame and checks it cycle by cycle.
  task automatic run_frame(input bit l, input bit r, input int hit_a, input int hit_b,
                           input int stray);
    int ox, oy, nx, ny, i, done_k, n_done, e_er, e_dr, e_id;
    bit hit, die;
    logic [2:0] dcol;
    logic [31:0] rnd;
    ox = m_x; oy = m_y;
    hit = m_hit || (hit_a >= 1 && hit_a <= N) || (hit_b >= 1 && hit_b <= N);
    if (hit) begin
      m_lives = m_lives - 1; nx = START_X; ny = START_Y;
    end else begin
      nx = model_move(ox, l, r); ny = oy;
    end
    m_hit = 0;
    die = (m_lives == 0);
    m_dead = die;
    m_x = nx; m_y = ny;
    dcol = 3'b111;
`ifdef PLAYER_HIT_FLASH_EN
    if (hit) dcol = 3'b100;
`endif
    tick = 1'b1; left = l; right = r;
    @(negedge clk);
    done_k = -1; n_done = 0; e_er = 0; e_dr = 0; e_id = 0;
    for (int k = 1; k <= 2 * N + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (k <= N) begin
        i = k - 1;
        if (!(plot && colour == 3'b000 && int'(plot_x) == ox + i % W &&
              int'(plot_y) == oy + i / W)) e_er++;
      end else if (!die && k >= N + 2 && k <= 2 * N + 1) begin
        i = k - N - 2;
        if (!(plot && colour == dcol && int'(plot_x) == nx + i % W &&
              int'(plot_y) == ny + i / W)) e_dr++;
      end else if (plot) begin
        e_id++;
      end
      rnd = $urandom;
      tick = (k == stray);
      got_hit = (k == hit_a) || (k == hit_b);
      left = rnd[0];
      right = rnd[1];
    end
    tick = 1'b0; got_hit = 1'b0; left = 1'b0; right = 1'b0;
    chk("erase_scan", e_er, 0);
    if (!die) chk("draw_scan", e_dr, 0);
    chk("idle_plot", e_id, 0);
    chk("done_cycle", done_k, die ? -1 : 2 * N + 2);
    chk("done_count", n_done, die ? 0 : 1);
    chk("x_pos", int'(x_pos), nx);
    chk("y_pos", int'(y_pos), ny);
    chk("lives", int'(lives), m_lives);
    chk("dead", int'(dead), int'(die));
  endtask

  task automatic dead_ignores();
    int n_plot, n_done;
    n_plot = 0; n_done = 0;
    @(negedge clk);
    tick = 1'b1; got_hit = 1'b1;
    @(negedge clk);
    tick = 1'b0; got_hit = 1'b0;
    for (int k = 0; k < 2 * N + 4; k++) begin
      @(negedge clk);
      if (plot) n_plot++;
      if (done) n_done++;
    end
    chk("dead_plot", n_plot, 0);
    chk("dead_done", n_done, 0);
    chk("dead_flag", int'(dead), 1);
    chk("dead_lives", int'(lives), 0);
  endtask

  initial begin
    bit l, r;
    int ha, st;
    logic [31:0] rnd;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 79, 3};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 78, 3};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 78, 3};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 78, 3};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 77, 3};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 78, 2};

    do_reset();
    check_reset_values("reset");

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].hit) pulse_hit();
      run_frame(vecs[v].l, vecs[v].r, -1, -1, 0);
      chk("vec_x", int'(x_pos), vecs[v].exp_x);
      chk("vec_lives", int'(lives), vecs[v].exp_lives);
    end

    for (int f = 0; f < 79; f++) run_frame(1'b1, 1'b0, -1, -1, 0);
    chk("sat_left", int'(x_pos), 0);
    for (int f = 0; f < 157; f++) run_frame(1'b0, 1'b1, -1, -1, 0);
    chk("sat_right", int'(x_pos), 156);

    do_reset();
    run_frame(1'b0, 1'b1, 3, 8, 0);
    chk("double_hit_lives", int'(lives), 2);
    chk("double_hit_x", int'(x_pos), START_X);

    do_reset();
    for (int f = 0; f < 3; f++) begin
      pulse_hit();
      run_frame(1'b1, 1'b0, -1, -1, 0);
    end
    chk("three_hits_dead", int'(dead), 1);
    dead_ignores();

    do_reset();
    @(negedge clk);
    tick = 1'b1; right = 1'b1;
    @(negedge clk);
    tick = 1'b0; right = 1'b0;
    for (int k = 1; k <= N + 7; k++) if (k > 1) @(negedge clk);
    chk("draw_px5_plot", int'(plot), 1);
    chk("draw_px5_x", int'(plot_x), 80);
    chk("draw_px5_y", int'(plot_y), 101);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    reset_n = 1'b0;
    model_reset();
    run_frame(1'b0, 1'b1, -1, -1, 0);

    for (int it = 0; it < 40; it++) begin
      if (m_dead) begin
        dead_ignores();
        do_reset();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) pulse_hit();
      rnd = $urandom;
      l = rnd[0];
      r = rnd[1];
      ha = ($urandom_range(0, 7) == 0) ? $urandom_range(1, N) : -1;
      st = rnd[2] ? $urandom_range(2, 2 * N + 1) : 0;
      run_frame(l, r, ha, -1, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
